// File: rtl/hazard_scoreboard_if.sv
// Fetch/decode hazard-unit bus: candidate instruction and its register
// usage from fetch, issue decision and forwarding selects back.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 8,
  parameter int DEPTH    = 3
) ();

  localparam int REG_W = $clog2(NUM_REGS);
  localparam int FWD_W = $clog2(DEPTH + 1);

  logic [15:0]      instr;
  logic             instr_valid;
  logic             src_a_vld;
  logic             src_b_vld;
  logic [REG_W-1:0] src_a;
  logic [REG_W-1:0] src_b;
  logic             reg_write;
  logic [REG_W-1:0] dest_reg;
  logic             is_load;
  logic             br_or_j;

  logic [15:0]      next_instr;
  logic             stall;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  logic [15:0]      stall_count;

  modport master (
    output instr, instr_valid, src_a_vld, src_b_vld, src_a, src_b,
           reg_write, dest_reg, is_load, br_or_j,
    input  next_instr, stall, fwd_a, fwd_b, stall_count
  );

  modport slave (
    input  instr, instr_valid, src_a_vld, src_b_vld, src_a, src_b,
           reg_write, dest_reg, is_load, br_or_j,
    output next_instr, stall, fwd_a, fwd_b, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Registered scoreboard of in-flight register writes between fetch and
// decode: RAW stall or forwarding selects, branch-shadow NOP insertion.
module hazard_scoreboard #(
  parameter int NUM_REGS  = 8,
  parameter int DEPTH     = 3,
  parameter int FWD_EN    = 0,
  parameter int BR_SHADOW = 3
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam int REG_W = $clog2(NUM_REGS);
  localparam int FWD_W = $clog2(DEPTH + 1);
  localparam int SH_W  = $clog2(BR_SHADOW + 1);

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] dest;
    logic             load;
  } slot_t;

  typedef enum logic {
    RUN,
    SHADOW
  } state_t;

  slot_t            slot_q [DEPTH];
  slot_t            new_slot;
  state_t           state_q, state_d;
  logic [SH_W-1:0]  shadow_cnt_q, shadow_cnt_d;
  logic [15:0]      stall_cnt_q;

  logic [DEPTH-1:0] hit_a, hit_b;
  logic [FWD_W-1:0] young_a, young_b;
  logic             data_stall;
  logic             stall;
  logic             issue;

  // ---------------------------------------------------------------------
  // Source/slot comparison
  // ---------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit_a[k] = bus.src_a_vld & slot_q[k].vld & (slot_q[k].dest == bus.src_a);
      hit_b[k] = bus.src_b_vld & slot_q[k].vld & (slot_q[k].dest == bus.src_b);
    end
  end

  // Walk oldest to youngest so the lowest hitting slot wins.
  always_comb begin
    young_a = '0;
    young_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit_a[k]) young_a = FWD_W'(k + 1);
      if (hit_b[k]) young_b = FWD_W'(k + 1);
    end
  end

  always_comb begin
    data_stall = 1'b0;
    if (FWD_EN != 0) begin
      // Only a load one cycle ahead cannot be bypassed.
      data_stall = (hit_a[0] | hit_b[0]) & slot_q[0].load;
    end else begin
      data_stall = |{hit_a, hit_b};
    end
  end

  // Gating with rst_n keeps the outputs quiet while reset is held.
  assign stall = rst_n & bus.instr_valid & (data_stall | (state_q == SHADOW));
  assign issue = rst_n & bus.instr_valid & ~stall;

  assign bus.stall       = stall;
  assign bus.next_instr  = issue ? bus.instr : NOP_INSTR;
  assign bus.fwd_a       = ((FWD_EN != 0) && !stall) ? young_a : '0;
  assign bus.fwd_b       = ((FWD_EN != 0) && !stall) ? young_b : '0;
  assign bus.stall_count = stall_cnt_q;

  // ---------------------------------------------------------------------
  // Scoreboard shift register
  // ---------------------------------------------------------------------
  always_comb begin
    new_slot = '0;
    if (issue) begin
      new_slot.vld  = bus.reg_write;
      new_slot.dest = bus.dest_reg;
      new_slot.load = bus.is_load;
    end
  end

  // NOTE: the slot array is reset, unlike a data RAM: a stale vld bit after
  // reset would raise a false hazard on the first instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every slot read its neighbour's
      // pre-edge value, so the shift order in this loop does not matter.
      slot_q[0] <= new_slot;
      for (int k = 1; k < DEPTH; k++) slot_q[k] <= slot_q[k-1];
    end
  end

  // ---------------------------------------------------------------------
  // Control-shadow FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    shadow_cnt_d = shadow_cnt_q;
    unique case (state_q)
      RUN: begin
        if (issue && bus.br_or_j) begin
          state_d      = SHADOW;
          shadow_cnt_d = SH_W'(BR_SHADOW);
        end
      end
      SHADOW: begin
        shadow_cnt_d = shadow_cnt_q - SH_W'(1);
        if (shadow_cnt_q == SH_W'(1)) state_d = RUN;
      end
      default: begin
        state_d      = RUN;
        shadow_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      shadow_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      shadow_cnt_q <= shadow_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule
